// File: rtl/decimator_by2.sv
// Rate-2 decimating direct-form FIR with valid/ready streaming and bypass.
// Optional synchronous flush input enabled by defining DECIM_FLUSH_EN.
module decimator_by2 #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int N_TAPS      = 8,
    parameter logic signed [N_TAPS-1:0][COEFF_WIDTH-1:0] COEFFS = '0,
    localparam int OUTPUT_WIDTH =
        DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS) + 1
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           bypass,
`ifdef DECIM_FLUSH_EN
    input  logic                           flush_in,
`endif
    input  logic signed [DATA_WIDTH-1:0]   src_data_in,
    input  logic                           src_valid_in,
    output logic                           src_ready_out,
    output logic signed [OUTPUT_WIDTH-1:0] dst_data_out,
    output logic                           dst_valid_out,
    input  logic                           dst_ready_in
);

    localparam int PW  = DATA_WIDTH + COEFF_WIDTH;
    localparam int EXT = OUTPUT_WIDTH - PW;
    localparam int BXT = OUTPUT_WIDTH - DATA_WIDTH;

    logic [N_TAPS-1:0][DATA_WIDTH-1:0] x_q, x_d;
    logic                              phase_q, phase_d;
    logic signed [OUTPUT_WIDTH-1:0]    out_q, out_d;
    logic                              out_valid_q, out_valid_d;

    logic                           flush;
    logic                           filt_ready;
    logic                           acc;
    logic                           fire;
    logic signed [OUTPUT_WIDTH-1:0] sum;
    logic signed [OUTPUT_WIDTH-1:0] byp_data;

`ifdef DECIM_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    // Phase-0 samples never touch out_q, so they are always welcome.
    assign filt_ready = ~flush & (~phase_q | ~out_valid_q | dst_ready_in);
    assign acc  = src_valid_in & filt_ready & ~bypass;
    assign fire = out_valid_q & ~flush & dst_ready_in & ~bypass;

    assign byp_data = {{BXT{src_data_in[DATA_WIDTH-1]}}, src_data_in}
                      << (COEFF_WIDTH - 1);

    assign src_ready_out = bypass ? dst_ready_in : filt_ready;
    assign dst_valid_out = bypass ? src_valid_in : (out_valid_q & ~flush);
    assign dst_data_out  = bypass ? byp_data : out_q;

    always_comb begin
        logic signed [DATA_WIDTH-1:0] tap;
        logic signed [PW-1:0]         prod;
        sum  = '0;
        tap  = '0;
        prod = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            tap  = (k == 0) ? src_data_in : $signed(x_q[(k == 0) ? 0 : k-1]);
            prod = $signed(COEFFS[k]) * tap;
            sum  = sum + {{EXT{prod[PW-1]}}, prod};
        end
    end

    always_comb begin
        x_d         = x_q;
        phase_d     = phase_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            x_d         = '0;
            phase_d     = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            if (fire) begin
                out_valid_d = 1'b0;
            end
            if (acc) begin
                x_d     = {x_q[N_TAPS-2:0], src_data_in};
                phase_d = ~phase_q;
                if (phase_q) begin
                    out_d       = sum;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x_q         <= '0;
            phase_q     <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            phase_q     <= phase_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_decimator_by2.sv
// Directed testbench for decimator_by2 with COEFFS[k] = k+1, N_TAPS = 8.
// Flush checks are compiled in when DECIM_FLUSH_EN is defined.
module tb_decimator_by2;

    localparam int OW = 36;

    logic                  clk;
    logic                  arst_n;
    logic                  bypass;
    logic                  flush_in;
    logic signed [15:0]    src_data_in;
    logic                  src_valid_in;
    logic                  src_ready_out;
    logic signed [OW-1:0]  dst_data_out;
    logic                  dst_valid_out;
    logic                  dst_ready_in;

    int checks   = 0;
    int failures = 0;

    decimator_by2 #(
        .DATA_WIDTH (16),
        .COEFF_WIDTH(16),
        .N_TAPS     (8),
        .COEFFS     ({16'sd8, 16'sd7, 16'sd6, 16'sd5,
                      16'sd4, 16'sd3, 16'sd2, 16'sd1})
    ) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .bypass       (bypass),
`ifdef DECIM_FLUSH_EN
        .flush_in     (flush_in),
`endif
        .src_data_in  (src_data_in),
        .src_valid_in (src_valid_in),
        .src_ready_out(src_ready_out),
        .dst_data_out (dst_data_out),
        .dst_valid_out(dst_valid_out),
        .dst_ready_in (dst_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] d);
        int n;
        n = 0;
        src_data_in  = d;
        src_valid_in = 1'b1;
        while (!src_ready_out && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) chk("send_timeout", 0, 1);
        tick();
        src_valid_in = 1'b0;
    endtask

    longint imp_exp[8]  = '{2, 4, 6, 8, 0, 0, 0, 0};
    longint step_exp[8] = '{300, 1000, 2100, 3600, 3600, 3600, 3600, 3600};

    initial begin
        arst_n       = 1'b0;
        bypass       = 1'b0;
        flush_in     = 1'b0;
        src_data_in  = '0;
        src_valid_in = 1'b0;
        dst_ready_in = 1'b1;
        #3;
        chk("rst_valid", dst_valid_out, 0);
        chk("rst_data", dst_data_out, 0);
        chk("rst_ready", src_ready_out, 1);
        #9;
        arst_n = 1'b1;
        tick();

        // impulse: valid right after every second accept, gone after next
        for (int i = 0; i < 16; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            if (i % 2 == 1) begin
                chk("imp_valid", dst_valid_out, 1);
                chk($sformatf("imp_data%0d", i / 2), dst_data_out,
                    imp_exp[i/2]);
            end else begin
                chk("imp_idle", dst_valid_out, 0);
            end
        end
        tick();
        chk("imp_drain", dst_valid_out, 0);

        for (int i = 0; i < 16; i++) begin
            send(16'sd100);
            if (i % 2 == 1)
                chk($sformatf("step_data%0d", i / 2), dst_data_out,
                    step_exp[i/2]);
        end
        tick();

        // backpressure
        dst_ready_in = 1'b0;
        send(16'sd10);
        send(16'sd20);
        chk("bp_valid", dst_valid_out, 1);
        chk("bp_data", dst_data_out, 3340);
        chk("bp_ph0_ready", src_ready_out, 1);
        send(16'sd30);
        chk("bp_hold_data", dst_data_out, 3340);
        src_data_in  = 16'sd40;
        src_valid_in = 1'b1;
        chk("bp_ph1_ready", src_ready_out, 0);
        tick();
        chk("bp_ph1_ready2", src_ready_out, 0);
        chk("bp_hold_data2", dst_data_out, 3340);
        dst_ready_in = 1'b1;
        #1;
        chk("bp_release_ready", src_ready_out, 1);
        tick();
        src_valid_in = 1'b0;
        chk("bp_reload_valid", dst_valid_out, 1);
        chk("bp_reload_data", dst_data_out, 2800);
        tick();
        chk("bp_drained", dst_valid_out, 0);

        // pending output, then bypass
        dst_ready_in = 1'b0;
        send(16'sd1);
        send(16'sd2);
        chk("pend_data", dst_data_out, 1904);
        bypass = 1'b1;
        src_data_in  = -16'sd3;
        src_valid_in = 1'b1;
        dst_ready_in = 1'b1;
        #1;
        chk("byp_data", dst_data_out, -98304);
        chk("byp_valid", dst_valid_out, 1);
        chk("byp_ready", src_ready_out, 1);
        tick();
        tick();
        dst_ready_in = 1'b0;
        #1;
        chk("byp_ready0", src_ready_out, 0);
        src_valid_in = 1'b0;
        #1;
        chk("byp_valid0", dst_valid_out, 0);
        bypass = 1'b0;
        #1;
        chk("byp_pend_valid", dst_valid_out, 1);
        chk("byp_pend_data", dst_data_out, 1904);
        dst_ready_in = 1'b1;
        tick();
        send(16'sd0);
        send(16'sd0);
        chk("byp_line_kept", dst_data_out, 610);
        tick();

        // reset mid-pair
        send(16'sd9);
        arst_n = 1'b0;
        #2;
        chk("mrst_valid", dst_valid_out, 0);
        chk("mrst_data", dst_data_out, 0);
        chk("mrst_ready", src_ready_out, 1);
        #2;
        arst_n = 1'b1;
        tick();
        send(16'sd5);
        chk("mrst_ph0", dst_valid_out, 0);
        send(16'sd7);
        chk("mrst_valid2", dst_valid_out, 1);
        chk("mrst_data2", dst_data_out, 17);
        tick();

`ifdef DECIM_FLUSH_EN
        dst_ready_in = 1'b0;
        send(16'sd1);
        send(16'sd1);
        chk("fl_pend", dst_data_out, 44);
        send(16'sd2);
        flush_in     = 1'b1;
        src_data_in  = 16'sd50;
        src_valid_in = 1'b1;
        #1;
        chk("fl_ready", src_ready_out, 0);
        chk("fl_valid", dst_valid_out, 0);
        tick();
        flush_in     = 1'b0;
        src_valid_in = 1'b0;
        #1;
        chk("fl_cleared", dst_valid_out, 0);
        dst_ready_in = 1'b1;
        send(16'sd3);
        chk("fl_phase0", dst_valid_out, 0);
        send(16'sd4);
        chk("fl_line_zero", dst_data_out, 10);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
